// File: rtl/mmu.sv
// rtl/mmu.sv - sample memory: circular RAM written forward, read back newest-first
module mmu #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_in,
    input  logic              wrt_i,
    input  logic              read_i,
    input  logic [DATA_W-1:0] d_i,
    output logic [DATA_W-1:0] q_o
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] q_q, q_d;

    // A write always wins over a simultaneous read; q only moves on a lone read.
    always_comb begin
        ptr_d   = ptr_q;
        q_d     = q_q;
        rd_addr = ptr_q - ONE;
        if (wrt_i) begin
            ptr_d = ptr_q + ONE;
        end else if (read_i) begin
            ptr_d = rd_addr;
            q_d   = mem[rd_addr];
        end
    end

    always_ff @(posedge clk_i or posedge rst_in) begin
        if (rst_in) begin
            ptr_q <= '0;
            q_q   <= '0;
        end else begin
            ptr_q <= ptr_d;
            q_q   <= q_d;
        end
    end

    // RAM contents survive reset; only the pointer is re-based to slot 0.
    always_ff @(posedge clk_i) begin
        if (wrt_i && !rst_in) begin
            mem[ptr_q] <= d_i;
        end
    end

    assign q_o = q_q;
endmodule

// File: tb/tb_mmu.sv
// tb/tb_mmu.sv - randomized and directed bench for mmu against a LIFO-ring model
module tb_mmu;
    localparam int DEPTH = 32;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wrt = 1'b0;
    logic        rd  = 1'b0;
    logic [31:0] din = '0;
    logic [31:0] q;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_mem [DEPTH];
    bit          m_wr  [DEPTH];
    int          m_ptr = 0;
    logic [31:0] m_q   = '0;
    bit          m_q_known = 1'b1;

    mmu #(.ADDR_W(5), .DATA_W(32)) dut (
        .clk_i (clk),
        .rst_in(rst),
        .wrt_i (wrt),
        .read_i(rd),
        .d_i   (din),
        .q_o   (q)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    // Inputs are applied 4 ns after a rising edge; the model advances with the next edge.
    task automatic step(input bit w, input bit r, input logic [31:0] d);
        wrt = w;
        rd  = r;
        din = d;
        @(posedge clk);
        #4;
        if (w) begin
            m_mem[m_ptr] = d;
            m_wr[m_ptr]  = 1'b1;
            m_ptr = (m_ptr + 1) % DEPTH;
        end else if (r) begin
            m_ptr = (m_ptr + DEPTH - 1) % DEPTH;
            m_q = m_mem[m_ptr];
            m_q_known = m_wr[m_ptr];
        end
        wrt = 1'b0;
        rd  = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        check("reset_async_q", q, 32'h0);
        m_ptr = 0;
        m_q = '0;
        m_q_known = 1'b1;
        @(posedge clk);
        #4;
        rst = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            m_wr[i]  = 1'b0;
            m_mem[i] = '0;
        end
        #1;
        check("reset_initial_q", q, 32'h0);
        @(posedge clk);
        #4;
        rst = 1'b0;

        step(1, 0, 32'hDEADBEEF);
        step(0, 1, 32'h0);
        check("pre_reset_q", q, 32'hDEADBEEF);
        do_reset();

        step(1, 0, 32'h11111111);
        step(1, 0, 32'h22222222);
        step(1, 0, 32'h33333333);
        step(0, 1, 32'h0); check("order_r1", q, 32'h33333333);
        step(0, 1, 32'h0); check("order_r2", q, 32'h22222222);
        step(0, 1, 32'h0); check("order_r3", q, 32'h11111111);

        step(1, 0, 32'hA);
        step(0, 1, 32'h0); check("inter_r1", q, 32'hA);
        step(1, 0, 32'hB);
        step(1, 0, 32'hC);
        step(0, 1, 32'h0); check("inter_r2", q, 32'hC);
        step(0, 1, 32'h0); check("inter_r3", q, 32'hB);

        step(1, 0, 32'h5);
        step(1, 1, 32'h6); check("collide_hold", q, 32'hB);
        step(0, 1, 32'h0); check("collide_r1", q, 32'h6);
        step(0, 1, 32'h0); check("collide_r2", q, 32'h5);

        do_reset();
        for (int i = 0; i <= 32; i++) step(1, 0, 32'(i));
        for (int i = 0; i < 32; i++) begin
            step(0, 1, 32'h0);
            check($sformatf("wrap_r%0d", i), q, 32'(32 - i));
        end

        step(1, 0, 32'h77);
        step(0, 1, 32'h0);
        check("hold_read", q, 32'h77);
        for (int i = 0; i < 10; i++) begin
            step(0, 0, 32'(i));
            check("hold_idle", q, 32'h77);
        end

        do_reset();
        for (int i = 0; i < 600; i++) begin
            int sel;
            sel = int'($urandom_range(0, 99));
            if (sel < 2) begin
                do_reset();
            end else begin
                step(sel < 45 || (sel >= 90 && sel < 95), sel >= 45 && sel < 95 ? (sel >= 90) || (sel >= 45 && sel < 85) : 1'b0, $urandom());
                if (m_q_known) check("rand_q", q, m_q);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mmu.md
# mmu

Sample memory management unit for the logic-analyzer core. It stores 32-bit sample words into an internal circular RAM as they are captured. During readout it returns them most-recent-first, so the most recent capture leaves first. It sits between the trigger/sampler stage (writer) and the transmitter (reader).

## Interface
Parameters:
- ADDR_W, default 5: RAM address width; depth = 2**ADDR_W words.
- DATA_W, default 32: sample word width; ports below use 32.

Ports:
- clk_i  in  1  single system clock; all state updates on its rising edge.
- rst_in  in  1  asynchronous, active-high reset.
- wrt_i  in  1  write strobe; store d_i this cycle.
- read_i  in  1  read strobe; fetch previous word this cycle.
- d_i  in  32  sample word to store.
- q_o  out  32  registered read data.

## Operation
- State:
  - one pointer ptr[ADDR_W-1:0] (next write slot);
  - RAM mem[2**ADDR_W] of DATA_W bits;
  - output register q_o.
- Reset (rst_in=1, asynchronous):
  - ptr=0, q_o=0 immediately.
  - RAM contents are not cleared.
- Write (wrt_i=1): mem[ptr] <= d_i; ptr <= ptr+1 (mod 2**ADDR_W).
- Read (wrt_i=0, read_i=1):
  - ptr <= ptr-1 (mod 2**ADDR_W);
  - q_o <= mem[ptr-1].
  - Consecutive reads therefore return words newest-first.
- Simultaneous wrt_i=1 and read_i=1: write wins, read ignored, q_o holds.
- Idle (both 0): ptr, RAM and q_o hold.
- Wrap-around: pointer arithmetic is modular.
  - Writes beyond depth overwrite the oldest words.
  - Reads beyond the number of stored words continue backward through the RAM and return whatever it holds (undefined if never written).
- No full/empty flags; the controller counts samples itself.
- No combinational path from inputs to q_o.

## Timing
- Inputs sampled on the rising edge of clk_i. The bench drives them half a clock period minus 1 ns after the edge and samples q_o just before the edge.
- Write latency: the word is stored at the edge where wrt_i=1. A read strobe on the very next cycle returns it.
- Read latency: 1 cycle. q_o updates at the edge where read_i=1 and is stable until the next read or reset.
- Back-to-back strobes, including alternating write/read every cycle, are supported at full clock rate.
- Reset asserted mid-operation: pointer returns to 0 asynchronously. Words already in RAM remain but are addressed from slot 0 afterwards.
- Deassertion of rst_in is synchronized externally; the first valid strobe is the edge after release.

## Test plan
- Reset: assert rst_in with q_o previously 0xDEADBEEF -> q_o=0x00000000 immediately, without waiting for a clock edge.
- Write/read order:
  - stimulus: write 0x11111111, 0x22222222, 0x33333333 on consecutive cycles, then assert read_i 3 cycles;
  - response: q_o = 0x33333333, 0x22222222, 0x11111111, each one cycle after its strobe.
- Interleaved:
  - stimulus: write 0xA, read, write 0xB, write 0xC, read, read;
  - response: reads return 0xA, then 0xC, then 0xB.
- Simultaneous strobes:
  - stimulus: write 0x5 alone, then one cycle with both strobes and d_i=0x6, then read twice;
  - response: q_o unchanged during the collision cycle, then q_o=0x6, then 0x5.
- Wrap-around:
  - stimulus: write 33 words 0..32 (depth 32), then read 32 times;
  - response: q_o = 32, 31, …, 1; word 0 was overwritten.
- Hold: no strobes for 10 cycles after a read of 0x77 -> q_o stays 0x77.
